mio_bus_ctrl: RTL

Memory/IO bus controller that sits directly downstream of the multi-cycle MIPS CPU. It consumes the CPU's address, write data and mem_r/mem_w strobes, and decodes the address to block RAM, a write-only VRAM port, a GPIO register or a free-running counter. It returns read data and the MIO_ready handshake that stalls the CPU's memory states. Transfers are word-wide only.

---
 rtl/mio_bus_ctrl_pkg.sv | 28 ++
 rtl/mio_addr_decode.sv | 25 ++
 rtl/mio_bus_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mio_bus_ctrl_pkg.sv
// Shared types for the MIO bus controller: region codes, base nibbles, FSM states.
// Also used by the CPU-side debug display through mio_addr_decode.
package mio_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_VRAM,
        REG_GPIO,
        REG_CNT,
        REG_NONE
    } region_t;

    localparam logic [3:0] VRAM_BASE = 4'h4;
    localparam logic [3:0] GPIO_BASE = 4'hE;
    localparam logic [3:0] CNT_BASE  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAM_WAIT,
        ST_RESP
    } state_t;

    // RAM occupies the four lowest 256 MB windows (nibbles 0x0..0x3).
    function automatic logic is_ram_nibble(input logic [3:0] nib);
        return nib[3:2] == 2'b00;
    endfunction

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational region decode of the top address nibble; zero latency.
// Pure function of its input, so no flow control is involved.
module mio_addr_decode
    import mio_bus_ctrl_pkg::*;
(
    input  logic [3:0] addr_hi,
    output region_t    region,
    output logic       unmapped
);

    always_comb begin
        region = REG_NONE;
        if (is_ram_nibble(addr_hi)) begin
            region = REG_RAM;
        end else if (addr_hi == VRAM_BASE) begin
            region = REG_VRAM;
        end else if (addr_hi == GPIO_BASE) begin
            region = REG_GPIO;
        end else if (addr_hi == CNT_BASE) begin
            region = REG_CNT;
        end
        unmapped = (region == REG_NONE);
    end

endmodule

// File: rtl/mio_bus_ctrl.sv
// CPU memory/IO bus controller: peripherals answer 1 cycle after decode, RAM after RAM_LAT+2.
// The CPU holds its request until mio_ready; request changes outside IDLE are ignored.
module mio_bus_ctrl
    import mio_bus_ctrl_pkg::*;
#(
    parameter int          RAM_AW   = 10,
    parameter int          RAM_LAT  = 1,
    parameter int          VRAM_AW  = 15,
    parameter logic [31:0] GPIO_RST = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        cpu_addr,
    input  logic [31:0]        cpu_wdata,
    input  logic               cpu_mem_r,
    input  logic               cpu_mem_w,
    output logic [31:0]        cpu_rdata,
    output logic               mio_ready,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic [31:0]        ram_wdata,
    output logic               ram_en,
    output logic               ram_we,
    input  logic [31:0]        ram_rdata,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [31:0]        vram_wdata,
    output logic               vram_we,
    input  logic [31:0]        gpio_in,
    output logic [31:0]        gpio_out,
    output logic               bus_err
);

    localparam logic [2:0] LAT_INIT = 3'(RAM_LAT);

    state_t      state;
    region_t     region;
    logic        unmapped;
    logic [2:0]  wait_cnt;
    logic        is_write;
    logic [31:0] counter;
    logic [31:0] periph_rdata;
    logic        req;
    logic        dual;
    logic        accept;
    logic        cnt_wr;
    logic        unused_addr;

    mio_addr_decode u_decode (
        .addr_hi  (cpu_addr[31:28]),
        .region   (region),
        .unmapped (unmapped)
    );

    assign req    = cpu_mem_r | cpu_mem_w;
    assign dual   = cpu_mem_r & cpu_mem_w;
    assign accept = (state == ST_IDLE) && req;
    assign cnt_wr = accept && cpu_mem_w && (region == REG_CNT);

    // Only some address bits feed the RAM/VRAM word addresses; the rest are don't-care.
    assign unused_addr = ^cpu_addr;

    always_comb begin
        periph_rdata = '0;
        case (region)
            REG_GPIO: periph_rdata = gpio_in;
            REG_CNT:  periph_rdata = counter;
            default:  periph_rdata = '0;
        endcase
    end

    // Free-running counter; a CPU store at the decode edge replaces that edge's increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter <= '0;
        end else if (cnt_wr) begin
            counter <= cpu_wdata;
        end else begin
            counter <= counter + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            mio_ready  <= 1'b0;
            cpu_rdata  <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            vram_we    <= 1'b0;
            gpio_out   <= GPIO_RST;
            bus_err    <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            is_write   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        is_write   <= cpu_mem_w;
                        ram_addr   <= cpu_addr[RAM_AW+1:2];
                        ram_wdata  <= cpu_wdata;
                        vram_addr  <= cpu_addr[VRAM_AW+1:2];
                        vram_wdata <= cpu_wdata;
                        if (unmapped || dual) begin
                            bus_err <= 1'b1;
                        end
                        if (region == REG_RAM) begin
                            state    <= ST_RAM_WAIT;
                            wait_cnt <= LAT_INIT;
                            ram_en   <= 1'b1;
                            ram_we   <= cpu_mem_w;
                        end else begin
                            state     <= ST_RESP;
                            mio_ready <= 1'b1;
                            if (!cpu_mem_w) begin
                                cpu_rdata <= periph_rdata;
                            end else if (region == REG_GPIO) begin
                                gpio_out <= cpu_wdata;
                            end else if (region == REG_VRAM) begin
                                vram_we <= 1'b1;
                            end
                        end
                    end
                end
                ST_RAM_WAIT: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    if (wait_cnt == 3'd0) begin
                        state     <= ST_RESP;
                        mio_ready <= 1'b1;
                        if (!is_write) begin
                            cpu_rdata <= ram_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    mio_ready <= 1'b0;
                    vram_we   <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
